// File: rtl/div_unit_pkg.sv
// Shared state type and counter width for the div_unit_32b divider.
package div_unit_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // Enough bits to count all quotient steps of a 32-bit divide.
  localparam int CNT_W = 6;

endpackage

// File: rtl/div_unit_dpath.sv
// Datapath for the restoring divider: remainder, quotient/dividend shift register,
// divisor register and the nbits+1-bit trial subtractor.
module div_unit_dpath
  import div_unit_pkg::*;
#(
  parameter int nbits = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             load_zero,
  input  logic             step,
  input  logic [nbits-1:0] dividend,
  input  logic [nbits-1:0] divisor,
  output logic [nbits-1:0] quot,
  output logic [nbits-1:0] rem
);

  logic [nbits-1:0] rem_q;
  logic [nbits-1:0] quot_q;
  logic [nbits-1:0] divisor_q;
  logic [nbits:0]   shifted;
  logic [nbits:0]   diff;

  // quot_q starts out holding the dividend; its MSB feeds the remainder each step.
  always_comb begin
    shifted = {rem_q, quot_q[nbits-1]};
    diff    = shifted - {1'b0, divisor_q};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
    end else if (load_zero) begin
      rem_q     <= dividend;
      quot_q    <= '1;
      divisor_q <= divisor;
    end else if (load) begin
      rem_q     <= '0;
      quot_q    <= dividend;
      divisor_q <= divisor;
    end else if (step) begin
      rem_q  <= diff[nbits] ? shifted[nbits-1:0] : diff[nbits-1:0];
      quot_q <= {quot_q[nbits-2:0], ~diff[nbits]};
    end
  end

  assign quot = quot_q;
  assign rem  = rem_q;

endmodule

// File: rtl/div_unit_32b.sv
// Unsigned sequential divider with valid/ready handshakes, one quotient bit per cycle.
// Define DIV_UNIT_EARLY_ZERO_EN to finish divide-by-zero in one cycle.
module div_unit_32b
  import div_unit_pkg::*;
#(
  parameter int nbits = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [nbits-1:0] in_dividend,
  input  logic [nbits-1:0] in_divisor,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [nbits-1:0] out_quot,
  output logic [nbits-1:0] out_rem
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             zero_div;
  logic             load;
  logic             load_zero;
  logic             step;
  logic [nbits-1:0] dp_quot;
  logic [nbits-1:0] dp_rem;

`ifdef DIV_UNIT_EARLY_ZERO_EN
  assign zero_div = (in_divisor == '0);
`else
  assign zero_div = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= '0;
      end else if (state_q == CALC) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // in_rdy is masked by reset so nothing is offered while reset is held.
  always_comb begin
    state_d   = state_q;
    in_rdy    = 1'b0;
    out_val   = 1'b0;
    accept    = 1'b0;
    load      = 1'b0;
    load_zero = 1'b0;
    step      = 1'b0;
    case (state_q)
      IDLE: begin
        in_rdy = ~reset;
        if (in_val && in_rdy) begin
          accept    = 1'b1;
          load      = ~zero_div;
          load_zero = zero_div;
          state_d   = zero_div ? DONE : CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt_q == CNT_W'(nbits - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_val = 1'b1;
        if (out_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  div_unit_dpath #(
    .nbits(nbits)
  ) u_dpath (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_zero(load_zero),
    .step     (step),
    .dividend (in_dividend),
    .divisor  (in_divisor),
    .quot     (dp_quot),
    .rem      (dp_rem)
  );

  assign out_quot = (state_q == DONE) ? dp_quot : '0;
  assign out_rem  = (state_q == DONE) ? dp_rem  : '0;

endmodule

// File: tb/tb_div_unit_32b.sv
// Self-checking bench for div_unit_32b against a plain / and % reference model.
module tb_div_unit_32b;

  logic        clk;
  logic        reset;
  logic        in_val;
  logic        in_rdy;
  logic [31:0] in_dividend;
  logic [31:0] in_divisor;
  logic        out_val;
  logic        out_rdy;
  logic [31:0] out_quot;
  logic [31:0] out_rem;

  int total_cnt = 0;
  int bad_cnt   = 0;

  div_unit_32b #(.nbits(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_val     (in_val),
    .in_rdy     (in_rdy),
    .in_dividend(in_dividend),
    .in_divisor (in_divisor),
    .out_val    (out_val),
    .out_rdy    (out_rdy),
    .out_quot   (out_quot),
    .out_rem    (out_rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int expected_latency(input logic [31:0] b);
`ifdef DIV_UNIT_EARLY_ZERO_EN
    return (b == 32'd0) ? 1 : 33;
`else
    return 33;
`endif
  endfunction

  // One full transaction: handshake, scrambled inputs during the divide,
  // optional consumer stall, then the result handshake.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input int stall);
    logic [31:0] exp_q;
    logic [31:0] exp_r;
    int          lat;
    int          guard;
    exp_q = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
    exp_r = (b == 32'd0) ? a : a % b;
    guard = 0;
    while (!in_rdy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("in_rdy_idle", 64'(in_rdy), 64'd1);
    in_val      = 1'b1;
    in_dividend = a;
    in_divisor  = b;
    out_rdy     = (stall == 0);
    @(posedge clk);
    #1;
    in_val      = 1'($urandom_range(0, 1));
    in_dividend = $urandom;
    in_divisor  = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1 && !out_val) begin
        checkOutput("calc_quot_zero", 64'(out_quot), 64'd0);
        checkOutput("calc_rem_zero", 64'(out_rem), 64'd0);
      end
    end while (!out_val && lat < 200);
    checkOutput("latency", 64'(lat), 64'(expected_latency(b)));
    checkOutput("quot", 64'(out_quot), 64'(exp_q));
    checkOutput("rem", 64'(out_rem), 64'(exp_r));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checkOutput("stall_val", 64'(out_val), 64'd1);
      checkOutput("stall_quot", 64'(out_quot), 64'(exp_q));
      checkOutput("stall_rem", 64'(out_rem), 64'(exp_r));
      checkOutput("stall_in_rdy", 64'(in_rdy), 64'd0);
    end
    out_rdy = 1'b1;
    @(negedge clk);
    checkOutput("rdy_after_result", 64'(in_rdy), 64'd1);
    checkOutput("val_after_result", 64'(out_val), 64'd0);
    in_val = 1'b0;
  endtask

  initial begin
    int          seen;
    logic [31:0] ra;
    logic [31:0] rb;
    reset       = 1'b1;
    in_val      = 1'b0;
    in_dividend = '0;
    in_divisor  = '0;
    out_rdy     = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_in_rdy", 64'(in_rdy), 64'd0);
    checkOutput("reset_out_val", 64'(out_val), 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("post_reset_in_rdy", 64'(in_rdy), 64'd1);
    checkOutput("post_reset_quot", 64'(out_quot), 64'd0);
    @(negedge clk);

    applyStimulus(32'd100, 32'd7, 0);
    applyStimulus(32'hFFFF_FFFF, 32'd1, 0);
    applyStimulus(32'd5, 32'hFFFF_FFFF, 0);
    applyStimulus(32'd0, 32'd3, 0);
    applyStimulus(32'd5, 32'd0, 0);
    applyStimulus(32'd1000, 32'd10, 5);

    // Reset in the 10th CALC cycle of 77 / 5.
    in_val      = 1'b1;
    in_dividend = 32'd77;
    in_divisor  = 32'd5;
    @(posedge clk);
    #1;
    in_val = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("mid_reset_out_val", 64'(out_val), 64'd0);
    checkOutput("mid_reset_in_rdy", 64'(in_rdy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("mid_reset_rdy_after", 64'(in_rdy), 64'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_val) seen++;
    end
    checkOutput("no_stale_result", 64'(seen), 64'd0);
    applyStimulus(32'd9, 32'd2, 0);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (rb == 32'd0) rb = 32'd1;
      applyStimulus(ra, rb, 0);
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
